tdm_demux: RTL and testbench

TDM_DEMUX -- requirements
Module: tdm_demux

---
 rtl/tdm_demux.sv | 92 +++++++++
 tb/tb_tdm_demux.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux.sv
// Serial-to-parallel TDM demultiplexer: assembles CHANNELS words per frame,
// aligned on in_sof, into a one-deep output register with valid/ready handshakes.
module tdm_demux #(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   input  logic                      in_sof,
   input  logic [WIDTH-1:0]          in_data,
   output logic                      in_ready,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [CHANNELS*WIDTH-1:0] out_data,
   output logic                      err_sof,
   output logic                      drop
);
   localparam int CW = $clog2(CHANNELS);
   localparam logic [CW-1:0] LAST = CW'(CHANNELS - 1);

   typedef enum logic {IDLE, COLLECT} state_t;
   typedef logic [CHANNELS-1:0][WIDTH-1:0] frame_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   frame_t          frame_q, frame_d;
   frame_t          out_data_q, out_data_d;
   logic            out_valid_q, out_valid_d;
   logic            err_sof_q, err_sof_d;
   logic            drop_q, drop_d;
   logic            accept;

   // Stall only when the last slot would need the output register and it is still occupied.
   assign in_ready  = !(state_q == COLLECT && cnt_q == LAST && out_valid_q && !out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign err_sof   = err_sof_q;
   assign drop      = drop_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      frame_d     = frame_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q && !out_ready;
      err_sof_d   = 1'b0;
      drop_d      = 1'b0;
      if (accept) begin
         if (in_sof) begin
            // A start-of-frame always restarts assembly, even over a would-be last slot.
            frame_d[0] = in_data;
            cnt_d      = CW'(1);
            state_d    = COLLECT;
            err_sof_d  = (state_q == COLLECT);
         end else if (state_q == IDLE) begin
            drop_d = 1'b1;
         end else begin
            frame_d[cnt_q] = in_data;
            if (cnt_q == LAST) begin
               out_data_d  = frame_d;
               out_valid_d = 1'b1;
               state_d     = IDLE;
               cnt_d       = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         frame_q     <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         err_sof_q   <= 1'b0;
         drop_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         frame_q     <= frame_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         err_sof_q   <= err_sof_d;
         drop_q      <= drop_d;
      end
   end
endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (CHANNELS=4, WIDTH=8) with an expected-frame queue
// checked whenever the DUT hands a frame downstream.
module tb_tdm_demux;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_sof = 1'b0;
   logic [7:0]  in_data = '0;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_data;
   logic        err_sof;
   logic        drop;

   int total = 0;
   int bad = 0;
   int drop_cnt = 0;
   int err_cnt = 0;
   int stall_cnt = 0;
   int frames_seen = 0;
   logic [31:0] exp_q[$];

   tdm_demux #(.CHANNELS(4), .WIDTH(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .err_sof(err_sof), .drop(drop)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every output handshake and tallies pulses/stalls.
   always @(negedge clk) begin
      if (!rst) begin
         if (drop) drop_cnt++;
         if (err_sof) err_cnt++;
         if (in_valid && !in_ready) stall_cnt++;
         if (out_valid && out_ready) begin
            frames_seen++;
            if (exp_q.size() == 0) chk("unexpected_frame", out_data, 32'hxxxx_xxxx);
            else chk("frame", out_data, exp_q.pop_front());
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic s);
      int n;
      in_valid = 1'b1;
      in_sof   = s;
      in_data  = d;
      n = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 50) begin
            chk("send_timeout", 32'(n), 32'd0);
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic send_frame(input logic [31:0] f);
      send(f[7:0], 1'b1);
      send(f[15:8], 1'b0);
      send(f[23:16], 1'b0);
      send(f[31:24], 1'b0);
   endtask

   initial begin
      int d0, e0, s0, f0;
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, e0, s0, f0;
      // Reset state
      idle(2);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_err_drop", {30'd0, err_sof, drop}, 32'd0);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // Basic frame, latency of one cycle after last word
      d0 = drop_cnt; e0 = err_cnt;
      exp_q.push_back(32'h44332211);
      send(8'h11, 1'b1);
      send(8'h22, 1'b0);
      send(8'h33, 1'b0);
      chk("pre_last_valid", 32'(out_valid), 32'd0);
      send(8'h44, 1'b0);
      chk("latency_valid", 32'(out_valid), 32'd1);
      chk("latency_data", out_data, 32'h44332211);
      idle(3);
      chk("basic_no_pulses", 32'((drop_cnt - d0) + (err_cnt - e0)), 32'd0);
      chk("valid_drops", 32'(out_valid), 32'd0);

      // Unsynchronised words are dropped
      d0 = drop_cnt;
      send(8'hAA, 1'b0);
      send(8'hBB, 1'b0);
      exp_q.push_back(32'h04030201);
      send_frame(32'h04030201);
      idle(3);
      chk("drop_count", 32'(drop_cnt - d0), 32'd2);

      // Early sof aborts partial frame
      e0 = err_cnt;
      send(8'h01, 1'b1);
      send(8'h02, 1'b0);
      exp_q.push_back(32'h08070605);
      send_frame(32'h08070605);
      idle(3);
      chk("err_sof_count", 32'(err_cnt - e0), 32'd1);

      // Back-pressure: second frame's last word held until first frame leaves
      out_ready = 1'b0;
      exp_q.push_back(32'h13121110);
      exp_q.push_back(32'h17161514);
      send_frame(32'h13121110);
      send(8'h14, 1'b1);
      send(8'h15, 1'b0);
      send(8'h16, 1'b0);
      in_valid = 1'b1; in_sof = 1'b0; in_data = 8'h17;
      repeat (3) begin
         @(negedge clk);
         chk("bp_in_ready_low", 32'(in_ready), 32'd0);
         chk("bp_held_data", out_data, 32'h13121110);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_second_valid", 32'(out_valid), 32'd1);
      chk("bp_second_data", out_data, 32'h17161514);
      idle(2);

      // Reset mid-frame discards held output and partial frame
      out_ready = 1'b0;
      send_frame(32'hDEADBEEF);
      send(8'h31, 1'b1);
      send(8'h32, 1'b0);
      send(8'h33, 1'b0);
      rst = 1'b1;
      idle(1);
      chk("midrst_valid", 32'(out_valid), 32'd0);
      idle(1);
      chk("midrst_data", out_data, 32'd0);
      rst = 1'b0;
      out_ready = 1'b1;
      exp_q.push_back(32'h0D0C0B0A);
      send_frame(32'h0D0C0B0A);
      chk("post_rst_data", out_data, 32'h0D0C0B0A);
      idle(2);

      // Continuous back-to-back frames
      d0 = drop_cnt; e0 = err_cnt; s0 = stall_cnt; f0 = frames_seen;
      for (int i = 0; i < 3; i++) begin
         logic [31:0] f;
         f = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i+8'h80)};
         exp_q.push_back(f);
         send_frame(f);
      end
      idle(3);
      chk("b2b_stalls", 32'(stall_cnt - s0), 32'd0);
      chk("b2b_pulses", 32'((drop_cnt - d0) + (err_cnt - e0)), 32'd0);
      chk("b2b_frames", 32'(frames_seen - f0), 32'd3);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
